menu_controller: RTL and testbench

MENU_CONTROLLER -- requirements
Module: menu_controller

---
 rtl/menu_controller.sv | 89 ++++++++
 tb/tb_menu_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/menu_controller.sv
// menu_controller: three-state button menu (IDLE/BROWSE/ISSUE) issuing one valid/ready command per selection.
// Define MENU_TIMEOUT_EN to enable the BROWSE inactivity timeout (TIMEOUT_CYCLES idle cycles).
module menu_controller #(
    parameter int N_ITEMS        = 6,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_sel,
    input  logic       btn_back,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_item,
    output logic [2:0] menu_idx,
    output logic       menu_active
);
    typedef enum logic [1:0] {IDLE, BROWSE, ISSUE} state_t;
    state_t state_q, state_d;
    logic [2:0] idx_q, idx_d, item_q, item_d;
    logic valid_q, valid_d, active_q, active_d;
    logic any_btn;
`ifdef MENU_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic timed_out;
    assign timed_out = cnt_q == 16'(TIMEOUT_CYCLES - 1);
`else
    logic [15:0] unused_timeout;
    logic timed_out;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign timed_out = 1'b0;
`endif
    assign any_btn = btn_next | btn_sel | btn_back;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        item_d  = item_q;
        case (state_q)
            IDLE: if (btn_next || btn_sel) begin
                state_d = BROWSE;
                idx_d   = 3'd0;
            end
            BROWSE: begin
                if (btn_back)
                    state_d = IDLE;
                else if (btn_sel) begin
                    state_d = ISSUE;
                    item_d  = idx_q;
                end else if (btn_next)
                    idx_d = (idx_q == 3'(N_ITEMS - 1)) ? 3'd0 : idx_q + 3'd1;
                else if (timed_out)
                    state_d = IDLE;
            end
            ISSUE: if (cmd_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        valid_d  = state_d == ISSUE;
        active_d = state_d != IDLE;
    end
`ifdef MENU_TIMEOUT_EN
    // Counts only uninterrupted stays in BROWSE; any pulse or exit restarts it.
    always_comb cnt_d = (state_q == BROWSE && state_d == BROWSE && !any_btn) ? cnt_q + 16'd1 : 16'd0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= 16'd0;
        else        cnt_q <= cnt_d;
`else
    logic unused_btn;
    assign unused_btn = any_btn;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            item_q   <= 3'd0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            item_q   <= item_d;
            valid_q  <= valid_d;
            active_q <= active_d;
        end
    end
    assign cmd_valid   = valid_q;
    assign cmd_item    = item_q;
    assign menu_idx    = idx_q;
    assign menu_active = active_q;
endmodule

// File: tb/tb_menu_controller.sv
// tb_menu_controller: directed scenarios plus randomized run against a behavioural menu model.
module tb_menu_controller;
    localparam int N = 6;
`ifdef MENU_TIMEOUT_EN
    localparam int TO = 10;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO = 1000;
    localparam bit TO_EN = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic btn_next = 1'b0, btn_sel = 1'b0, btn_back = 1'b0, cmd_ready = 1'b0;
    logic cmd_valid, menu_active;
    logic [2:0] cmd_item, menu_idx;
    int checks = 0, errors = 0;
    bit m_on, m_wait;
    int m_idx, m_item, m_quiet;

    menu_controller #(.N_ITEMS(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_sel(btn_sel),
        .btn_back(btn_back), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
        .cmd_item(cmd_item), .menu_idx(menu_idx), .menu_active(menu_active));

    always #5 clk = ~clk;

    // Menu behaviour: on = menu shown, wait = command pending, quiet = idle cycles while browsing.
    task automatic model(input bit n, s, b, r);
        if (!m_on) begin
            if (n || s) begin m_on = 1; m_idx = 0; m_quiet = 0; end
        end else if (m_wait) begin
            if (r) begin m_wait = 0; m_on = 0; end
        end else if (b) m_on = 0;
        else if (s) begin m_wait = 1; m_item = m_idx; end
        else if (n) begin m_idx = (m_idx + 1) % N; m_quiet = 0; end
        else if (TO_EN && m_quiet == TO - 1) m_on = 0;
        else m_quiet++;
    endtask

    task automatic cyc(input bit n, s, b, r);
        btn_next = n; btn_sel = s; btn_back = b; cmd_ready = r;
        @(posedge clk); #1;
        model(n, s, b, r);
        btn_next = 0; btn_sel = 0; btn_back = 0; cmd_ready = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk) rst_n = 0;
        m_on = 0; m_wait = 0; m_idx = 0; m_item = 0; m_quiet = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        m_on = 0; m_wait = 0; m_idx = 0; m_item = 0; m_quiet = 0;
        #2;
        checks++; if ({cmd_valid, menu_active} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {cmd_valid, menu_active}); end
        checks++; if ({cmd_item, menu_idx} !== 6'd0) begin errors++; $display("FAIL reset_idx: got %h want 0", {cmd_item, menu_idx}); end
        @(negedge clk) begin rst_n = 1; btn_sel = 1; end
        @(posedge clk); #1;
        btn_sel = 0;
        model(0, 1, 0, 0);
        checks++; if ({cmd_valid, menu_active, menu_idx} !== 5'b0_1_000) begin errors++; $display("FAIL first_edge_sel: got %b want 01000", {cmd_valid, menu_active, menu_idx}); end
    endtask

    task automatic test_browse_next();
        reset_dut();
        cyc(0, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        checks++; if ({menu_active, menu_idx} !== 4'b1_011) begin errors++; $display("FAIL sel_next3: got %b want 1011", {menu_active, menu_idx}); end
        repeat (2) cyc(1, 0, 0, 0);
        checks++; if (menu_idx !== 3'd5) begin errors++; $display("FAIL idx5: got %0d want 5", menu_idx); end
        cyc(1, 0, 0, 0);
        checks++; if ({menu_active, menu_idx} !== 4'b1_000) begin errors++; $display("FAIL wrap: got %b want 1000", {menu_active, menu_idx}); end
    endtask

    task automatic test_issue_hold();
        reset_dut();
        cyc(0, 1, 0, 0);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (4) begin
            checks++; if ({cmd_valid, cmd_item} !== 4'b1_010) begin errors++; $display("FAIL issue_hold: got %b want 1010", {cmd_valid, cmd_item}); end
            cyc(0, 0, 0, 0);
        end
        checks++; if ({cmd_valid, cmd_item} !== 4'b1_010) begin errors++; $display("FAIL issue_hold5: got %b want 1010", {cmd_valid, cmd_item}); end
        cyc(0, 0, 0, 1);
        checks++; if ({cmd_valid, menu_active} !== 2'b00) begin errors++; $display("FAIL issue_done: got %b want 00", {cmd_valid, menu_active}); end
    endtask

    task automatic test_issue_ignore();
        reset_dut();
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (3) cyc(1, 1, 1, 0);
        checks++; if ({cmd_valid, menu_active, cmd_item, menu_idx} !== 8'b1_1_001_001) begin errors++; $display("FAIL issue_ignore: got %b want 11001001", {cmd_valid, menu_active, cmd_item, menu_idx}); end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        checks++; if ({cmd_valid, menu_active} !== 2'b00) begin errors++; $display("FAIL ready_idle: got %b want 00", {cmd_valid, menu_active}); end
    endtask

    task automatic test_back_priority();
        reset_dut();
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        checks++; if ({menu_active, menu_idx} !== 4'b0_001) begin errors++; $display("FAIL back_next: got %b want 0001", {menu_active, menu_idx}); end
        cyc(0, 0, 1, 0);
        checks++; if (menu_active !== 1'b0) begin errors++; $display("FAIL idle_back: got %b want 0", menu_active); end
        cyc(1, 1, 1, 0);
        cyc(1, 1, 0, 0);
        checks++; if ({cmd_valid, cmd_item} !== 4'b1_000) begin errors++; $display("FAIL back_sel: got %b want 1000", {cmd_valid, cmd_item}); end
    endtask

    task automatic test_timeout();
        int fall = -1;
        reset_dut();
        cyc(1, 0, 0, 0);
        for (int k = 1; k <= TO + 3; k++) begin
            cyc(0, 0, 0, 0);
            if (!menu_active && fall < 0) fall = k;
        end
        checks++; if (fall !== (TO_EN ? TO : -1)) begin errors++; $display("FAIL timeout_fall: got %0d want %0d", fall, TO_EN ? TO : -1); end
        reset_dut();
        cyc(1, 0, 0, 0);
        repeat (TO - 1) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        checks++; if ({menu_active, menu_idx} !== 4'b1_001) begin errors++; $display("FAIL timeout_pulse: got %b want 1001", {menu_active, menu_idx}); end
    endtask

    task automatic test_reset_mid_issue();
        bit seen = 0;
        reset_dut();
        cyc(0, 1, 0, 0);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        checks++; if ({cmd_valid, menu_active, menu_idx} !== 5'd0) begin errors++; $display("FAIL async_reset: got %b want 00000", {cmd_valid, menu_active, menu_idx}); end
        m_on = 0; m_wait = 0; m_idx = 0; m_item = 0; m_quiet = 0;
        @(negedge clk) rst_n = 1;
        repeat (5) begin
            cyc(0, 0, 0, 1);
            if (cmd_valid) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL replay: got %b want 0", seen); end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            int lim = ((i / 500) % 2) ? 3 : 15;
            cyc($urandom_range(0, lim) == 0, $urandom_range(0, lim) == 0,
                $urandom_range(0, lim) == 0, $urandom_range(0, 2) == 0);
            checks++;
            if ({cmd_valid, menu_active, menu_idx} !== {m_wait, m_on, 3'(m_idx)}) begin
                errors++;
                $display("FAIL rand_state cyc %0d: got %b want %b", i, {cmd_valid, menu_active, menu_idx}, {m_wait, m_on, 3'(m_idx)});
            end
            if (m_wait) begin
                checks++;
                if (cmd_item !== 3'(m_item)) begin errors++; $display("FAIL rand_item cyc %0d: got %0d want %0d", i, cmd_item, m_item); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_browse_next();
        test_issue_hold();
        test_issue_ignore();
        test_back_priority();
        test_timeout();
        test_reset_mid_issue();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
